// File: rtl/everloop_rx_pkg.sv
// Shared everloop timing package: FSM state encoding, log2 helper and the
// pulse-width constants derived from the clock frequency (used by tx and rx).
package everloop_rx_pkg;

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_LO   = 2'd3;

  // Ceiling log2; log2(1) = 0.
  function automatic int log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int min_hi_cycles(input int mhz);
    return mhz;
  endfunction

  function automatic int thresh_cycles(input int mhz);
    return mhz * 9 / 2;
  endfunction

  function automatic int max_hi_cycles(input int mhz);
    return mhz * 12;
  endfunction

  function automatic int gap_cycles(input int mhz);
    return mhz * 50;
  endfunction

endpackage

// File: rtl/everloop_rx_sync.sv
// Line conditioning for everloop_rx: 2-flop synchronizer, optional 3-tap
// majority filter (EVERLOOP_RX_FILTER_EN) and edge detector.
module everloop_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], d};
  end

`ifdef EVERLOOP_RX_FILTER_EN
  logic [1:0] tap_q;
  logic       filt_q;
  logic       maj;

  // Two of three samples must agree, so an isolated one-cycle spike never passes.
  assign maj = (sync_q[1] & tap_q[0]) | (sync_q[1] & tap_q[1]) | (tap_q[0] & tap_q[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_q  <= 2'b00;
      filt_q <= 1'b0;
    end else begin
      tap_q  <= {tap_q[0], sync_q[1]};
      filt_q <= maj;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= level;
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/everloop_rx.sv
// everloop serial receiver: classifies high pulses by width, assembles MSB-first
// bytes into a byte memory and reports frame end. Filter option: EVERLOOP_RX_FILTER_EN.
module everloop_rx
  import everloop_rx_pkg::*;
#(
  parameter int input_clk_MHz = 50,
  parameter int FRAME_BYTES   = 141
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       everloop_d,
  output logic       wr_en,
  output logic [7:0] address,
  output logic [7:0] data,
  output logic       frame_done,
  output logic [7:0] byte_count,
  output logic       err_glitch,
  output logic       err_frame
);

  localparam int MIN_HI = min_hi_cycles(input_clk_MHz);
  localparam int THRESH = thresh_cycles(input_clk_MHz);
  localparam int MAX_HI = max_hi_cycles(input_clk_MHz);
  localparam int GAP    = gap_cycles(input_clk_MHz);
  localparam int CW     = log2(GAP) + 1;

  localparam logic [CW-1:0] MIN_C  = CW'(MIN_HI);
  localparam logic [CW-1:0] THR_C  = CW'(THRESH);
  localparam logic [CW-1:0] MAXH_C = CW'(MAX_HI);
  localparam logic [CW-1:0] GAP_C  = CW'(GAP);
  localparam logic [7:0]    FB_C   = 8'(FRAME_BYTES);

  logic          level, rise, fall;
  logic [CW-1:0] cnt, hi_w;
  logic [1:0]    state;
  logic [6:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          ovf, sticky;
  logic          bit_val;
  logic [7:0]    byte_nxt;

  everloop_rx_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (everloop_d),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // Counter is zeroed on the edge cycle itself, so the width of the level that
  // just ended is one more than the count.
  assign hi_w     = cnt + CW'(1);
  assign bit_val  = (hi_w >= THR_C);
  assign byte_nxt = {shreg, bit_val};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (rise | fall)   cnt <= '0;
    else if (cnt != GAP_C)  cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_SYNC;
      wr_en      <= 1'b0;
      address    <= 8'd0;
      data       <= 8'd0;
      frame_done <= 1'b0;
      byte_count <= 8'd0;
      err_glitch <= 1'b0;
      err_frame  <= 1'b0;
      shreg      <= 7'd0;
      bit_cnt    <= 3'd0;
      ovf        <= 1'b0;
      sticky     <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      err_glitch <= 1'b0;
      err_frame  <= 1'b0;
      if (wr_en) address <= address + 8'd1;

      case (state)
        ST_SYNC: begin
          if (!level && cnt == GAP_C) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (rise) state <= ST_HI;
        end
        ST_HI: begin
          if (fall) begin
            state <= ST_LO;
            if (hi_w < MIN_C) begin
              err_glitch <= 1'b1;
            end else begin
              shreg   <= byte_nxt[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (address < FB_C) begin
                  wr_en <= 1'b1;
                  data  <= byte_nxt;
                end else begin
                  ovf <= 1'b1;
                end
              end
            end
          end else if (hi_w >= MAXH_C) begin
            // Stuck-high line: drop the partial frame, remember the error for
            // the next frame end, and realign on a full gap.
            sticky  <= 1'b1;
            address <= 8'd0;
            bit_cnt <= 3'd0;
            state   <= ST_SYNC;
          end
        end
        ST_LO: begin
          if (cnt == GAP_C) begin
            frame_done <= 1'b1;
            byte_count <= address;
            err_frame  <= (bit_cnt != 3'd0) | ovf | sticky;
            address    <= 8'd0;
            bit_cnt    <= 3'd0;
            ovf        <= 1'b0;
            sticky     <= 1'b0;
            state      <= rise ? ST_HI : ST_IDLE;
          end else if (rise) begin
            state <= ST_HI;
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_everloop_rx.sv
// Scoreboard bench for everloop_rx at a scaled clock (4 MHz) and frame size (8).
module tb_everloop_rx;

  localparam int MHZ    = 4;
  localparam int FB     = 8;
  localparam int GAP    = MHZ * 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       everloop_d = 1'b0;
  logic       wr_en, frame_done, err_glitch, err_frame;
  logic [7:0] address, data, byte_count;

  typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { logic [7:0] cnt; logic err; } fr_t;

  wr_t wq[$];
  fr_t fq[$];
  int  checks = 0;
  int  failures = 0;
  int  glitch_sent = 0;
  int  glitch_seen = 0;
  logic prev_wr = 1'b0;

  always #10 clk = ~clk;

  everloop_rx #(.input_clk_MHz(MHZ), .FRAME_BYTES(FB)) dut (
    .clk        (clk),
    .rst        (rst),
    .everloop_d (everloop_d),
    .wr_en      (wr_en),
    .address    (address),
    .data       (data),
    .frame_done (frame_done),
    .byte_count (byte_count),
    .err_glitch (err_glitch),
    .err_frame  (err_frame)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  always @(negedge clk) begin
    wr_t w;
    fr_t f;
    if (!rst) begin
      if (wr_en) begin
        chk("wr_spacing", {31'd0, prev_wr}, 0);
        if (wq.size() == 0) chk("unexpected_wr", 1, 0);
        else begin
          w = wq.pop_front();
          chk("wr_addr", {24'd0, address}, {24'd0, w.addr});
          chk("wr_data", {24'd0, data}, {24'd0, w.data});
        end
      end
      if (frame_done) begin
        if (fq.size() == 0) chk("unexpected_frame_done", 1, 0);
        else begin
          f = fq.pop_front();
          chk("byte_count", {24'd0, byte_count}, {24'd0, f.cnt});
          chk("err_frame", {31'd0, err_frame}, {31'd0, f.err});
        end
      end else if (err_frame) begin
        chk("err_frame_without_done", 1, 0);
      end
      if (err_glitch) begin
        chk("err_glitch_expected", {31'd0, glitch_seen < glitch_sent}, 1);
        glitch_seen++;
      end
      prev_wr = wr_en;
    end
  end

  task automatic hold(input logic v, input int n);
    everloop_d = v;
    repeat (n) @(negedge clk);
  endtask

  // 1 = ~24 high / ~24 low, 0 = ~12 high / ~36 low (the 6/3 us shape at 4 MHz).
  task automatic send_bit(input logic b);
    int hi, lo;
    hi = b ? int'($urandom_range(20, 28)) : int'($urandom_range(8, 14));
    lo = 48 - hi + int'($urandom_range(0, 6));
    hold(1'b1, hi);
    hold(1'b0, lo);
  endtask

  // Short high pulse between bits; a single-cycle spike is removed by the filter.
  task automatic send_glitch(input int gw);
`ifdef EVERLOOP_RX_FILTER_EN
    if (gw > 1) glitch_sent++;
`else
    glitch_sent++;
`endif
    hold(1'b1, gw);
    hold(1'b0, int'($urandom_range(10, 20)));
  endtask

  // mode 0: random bytes, 1: 0,1,2,..., 2: 0xA5. gw>0 injects a glitch after bit 3 of byte 0.
  task automatic frame(input int n, input int extra_bits, input int mode, input int gw);
    logic [7:0] b[$];
    logic [7:0] v, xb;
    for (int i = 0; i < n; i++) begin
      v = (mode == 1) ? i[7:0] : (mode == 2) ? 8'hA5 : 8'($urandom);
      b.push_back(v);
      if (i < FB) wq.push_back('{addr: i[7:0], data: v});
    end
    fq.push_back('{cnt: (n < FB) ? n[7:0] : FB[7:0], err: (extra_bits != 0) || (n > FB)});
    for (int i = 0; i < n; i++)
      for (int k = 7; k >= 0; k--) begin
        send_bit(b[i][k]);
        if (i == 0 && k == 4 && gw > 0) send_glitch(gw);
      end
    xb = 8'($urandom);
    for (int k = 0; k < extra_bits; k++) send_bit(xb[k]);
    hold(1'b0, GAP + 40);
  endtask

  // Reset in the middle of bit 4 of byte 3: only bytes 1 and 2 are ever written.
  task automatic reset_frame();
    logic [7:0] b[4];
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    wq.push_back('{addr: 8'd0, data: b[0]});
    wq.push_back('{addr: 8'd1, data: b[1]});
    for (int i = 0; i < 2; i++)
      for (int k = 7; k >= 0; k--) send_bit(b[i][k]);
    for (int k = 7; k >= 5; k--) send_bit(b[2][k]);
    hold(1'b1, 6);
    rst = 1'b1;
    hold(1'b1, 3);
    rst = 1'b0;
    hold(1'b1, 10);
    hold(1'b0, 30);
    for (int k = 3; k >= 0; k--) send_bit(b[2][k]);
    for (int k = 7; k >= 0; k--) send_bit(b[3][k]);
    hold(1'b0, GAP + 40);
  endtask

  initial begin
    int n, xb, gw;
    rst = 1'b1;
    everloop_d = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {4'd0, wr_en, frame_done, err_glitch, err_frame, address, data, byte_count}, 0);
    rst = 1'b0;
    hold(1'b0, GAP + 40);

    frame(1, 0, 2, 0);        // single 0xA5
    frame(FB, 0, 1, 0);       // full frame
    frame(FB + 1, 0, 1, 0);   // one byte overflow
    frame(0, 5, 0, 0);        // partial byte only
    frame(2, 0, 0, 2);        // short pulse between bits
    frame(2, 0, 0, 1);        // one-cycle spike
    reset_frame();
    frame(3, 0, 0, 0);        // first frame after mid-frame reset

    for (int r = 0; r < 6; r++) begin
      n  = int'($urandom_range(1, FB + 2));
      xb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
      gw = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 3));
      frame(n, xb, 0, gw);
    end

    repeat (10) @(negedge clk);
    chk("wr_queue_drained", wq.size(), 0);
    chk("frame_queue_drained", fq.size(), 0);
    chk("glitch_count", glitch_seen, glitch_sent);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/everloop_rx.md
# everloop_rx

Single-wire LED-ring stream receiver: samples the everloop serial line, classifies each high pulse as a 1 or 0 by width, assembles MSB-first bytes and writes them to a byte memory. Frames are delimited by a long low (reset) gap. It sits beside the everloop transmitter as a loopback monitor and frame-capture block for chained LED segments and for self-test of the LED output path.

## Interface
- `input_clk_MHz`, default 50: clock frequency; all pulse widths derive from it.
- `FRAME_BYTES`, default 141: maximum bytes written per frame.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high; one clock domain.
- `everloop_d`  in  1  serial line; asynchronous to `clk`.
- `wr_en`  out  1  one-cycle byte write strobe.
- `address`  out  8  write address; 0 at frame start.
- `data`  out  8  received byte; valid while `wr_en` is high.
- `frame_done`  out  1  one-cycle pulse at frame end.
- `byte_count`  out  8  bytes received in the last completed frame; held until the next `frame_done`.
- `err_glitch`  out  1  one-cycle pulse when a high pulse is shorter than `MIN_HI`.
- `err_frame`  out  1  one-cycle pulse at frame end on a partial byte, an overflow or a `MAX_HI` abort.

## Operation
- Derived constants (cycles): `MIN_HI` = `input_clk_MHz`\*1, `THRESH` = `input_clk_MHz`\*9/2, `MAX_HI` = `input_clk_MHz`\*12, `GAP` = `input_clk_MHz`\*50.
- Input path: 2-flop synchronizer, then a registered copy for edge detection.
- Single counter, `log2(GAP)+1` bits, saturating at `GAP`. It clears on every synchronized edge.
- **FSM states:**
  - SYNC (after reset): wait for the line to stay low for `GAP` cycles, then go to IDLE. No outputs fire. This prevents misaligned capture when reset is released mid-frame.
  - IDLE: on rising edge, go to HI.
  - HI: count high cycles. At the falling edge, decide the bit:
    - width < `MIN_HI`: pulse `err_glitch`, discard the bit, go to LO.
    - width ≥ `THRESH`: shift in 1.
    - otherwise: shift in 0.
    - Then go to LO.
    - If the count reaches `MAX_HI` (line stuck high): set the sticky frame error, go to SYNC.
  - LO: count low cycles. On rising edge, go to HI. When the count reaches `GAP`, end the frame and go to IDLE.
- Bytes shift in MSB first. On the 8th bit:
  - If `address` < `FRAME_BYTES`: the next cycle asserts `wr_en` with `data`, then `address` increments.
  - Otherwise the byte is dropped and the overflow flag is set.
- **Frame end:**
  - Pulse `frame_done`.
  - Load `byte_count` with the number of bytes written.
  - Pulse `err_frame` if the bit counter ≠ 0, overflow is set, or the sticky error is set.
  - Clear `address`, the bit counter and the flags.
  - A `MAX_HI` abort is reported at the next `frame_done` after SYNC completes.
- Simultaneous events: the glitch decision and the 8th-bit completion are mutually exclusive, because a glitch never counts as a bit.
- Reset values: all outputs 0, state SYNC. Reset mid-frame discards the partial frame with no `frame_done`.

## Timing
- Line falling edge of the 8th bit → `wr_en`: 3 cycles (2 sync + 1 register). Add 2 with the filter.
- Pulse width is preserved through the synchronizer to within ±1 cycle. With the transmitter's 6 µs / 3 µs highs (300 / 150 cycles), the margin to `THRESH` (225) is ≥ 75 cycles.
- `frame_done` fires `GAP` cycles after the last synchronized falling edge. The transmitter's 815 µs reset gap always exceeds `GAP`.
- `wr_en` is never asserted in consecutive cycles; the minimum byte spacing is 8 bit periods.

## Configuration
- `EVERLOOP_RX_FILTER_EN` defined: a 3-tap majority filter follows the synchronizer. Single-cycle spikes are suppressed, and pipeline latency grows by 2 cycles.
- Not defined: the synchronizer output feeds edge detection directly. Single-cycle spikes reach the FSM and produce `err_glitch`.

## Structure
- Shared package holds:
  - the state encoding (SYNC, IDLE, HI, LO);
  - the `log2` width function;
  - the `MIN_HI` / `THRESH` / `MAX_HI` / `GAP` derivation, used by both transmitter and receiver.
- One sub-module, `everloop_rx_sync`: synchronizer, optional filter and edge detector, outputting level, rise and fall.
- The FSM, counter, shifter and address logic stay in `everloop_rx`.

## Test plan
- Send byte 0xA5 (1 = 300 high / 300 low, 0 = 150 high / 450 low), then 2500 cycles low → `wr_en` once with `address`=0, `data`=0xA5; `frame_done`, `byte_count`=1, no errors.
- Send 141 bytes 0x00..0x8C, then gap → 141 writes at addresses 0..140 with matching data; `byte_count`=141.
- Send 142 bytes → 141 writes; 142nd byte dropped; `err_frame` with `frame_done`; `byte_count`=141.
- Send 5 bits, then gap → no `wr_en`; `frame_done` with `err_frame`, `byte_count`=0.
- Inject a 20-cycle high pulse between bits → `err_glitch`; byte still decodes correctly. Inject a 1-cycle spike → `err_glitch` without the filter, nothing with the filter.
- Assert `rst` during bit 4 of byte 3, release mid-byte → no output until a `GAP` low elapses. The next full frame is captured from `address` 0.
